operand_stack: RTL

//  Parametrised operand register stack for the calculator datapath; next generation of the single
//  32-bit load register. Holds up to DEPTH operands of WIDTH bits with push/pop/load/swap/dup/clear.

---
 rtl/operand_stack.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - operand register stack with push/pop/load/swap/dup/clear and over/underflow flags
// OPERAND_STACK_STICKY_ERR_EN: when defined, ovf/unf hold until CLEAR or reset instead of pulsing.
module operand_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         cmd_valid,
   input  logic [2:0]                   cmd,
   input  logic [WIDTH-1:0]             data_in,
   output logic [WIDTH-1:0]             top,
   output logic [WIDTH-1:0]             next,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full,
   output logic                         ovf,
   output logic                         unf
);

   localparam int CW = $clog2(DEPTH+1);

   localparam logic [2:0] CMD_NOP   = 3'b000;
   localparam logic [2:0] CMD_PUSH  = 3'b001;
   localparam logic [2:0] CMD_POP   = 3'b010;
   localparam logic [2:0] CMD_LOAD  = 3'b011;
   localparam logic [2:0] CMD_SWAP  = 3'b100;
   localparam logic [2:0] CMD_DUP   = 3'b101;
   localparam logic [2:0] CMD_CLEAR = 3'b110;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    cnt;
   logic             ovf_q;
   logic             unf_q;

   logic [WIDTH-1:0] top_val;
   logic [WIDTH-1:0] next_val;
   logic             is_empty;
   logic             is_full;

   logic [CW-1:0]    cnt_nxt;
   logic             wr_push;
   logic             wr_top;
   logic             do_swap;
   logic             do_clr;
   logic             ovf_evt;
   logic             unf_evt;
   logic [WIDTH-1:0] push_data;

   // Entries at or above count are stale, so top/next are selected by count, never by raw index.
   always_comb begin
      top_val  = '0;
      next_val = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (int'(cnt) == i + 1) top_val  = mem[i];
         if (int'(cnt) == i + 2) next_val = mem[i];
      end
   end

   assign is_empty = (cnt == '0);
   assign is_full  = (cnt == CW'(DEPTH));

   always_comb begin
      cnt_nxt   = cnt;
      wr_push   = 1'b0;
      wr_top    = 1'b0;
      do_swap   = 1'b0;
      do_clr    = 1'b0;
      ovf_evt   = 1'b0;
      unf_evt   = 1'b0;
      push_data = data_in;
      if (cmd_valid) begin
         case (cmd)
            CMD_PUSH: begin
               if (is_full) begin
                  ovf_evt = 1'b1;
               end else begin
                  wr_push = 1'b1;
                  cnt_nxt = cnt + CW'(1);
               end
            end
            CMD_POP: begin
               if (is_empty) unf_evt = 1'b1;
               else          cnt_nxt = cnt - CW'(1);
            end
            CMD_LOAD: begin
               if (is_empty) begin
                  wr_push = 1'b1;
                  cnt_nxt = CW'(1);
               end else begin
                  wr_top = 1'b1;
               end
            end
            CMD_SWAP: begin
               if (cnt < CW'(2)) unf_evt = 1'b1;
               else              do_swap = 1'b1;
            end
            CMD_DUP: begin
               if (is_empty) begin
                  unf_evt = 1'b1;
               end else if (is_full) begin
                  ovf_evt = 1'b1;
               end else begin
                  wr_push   = 1'b1;
                  push_data = top_val;
                  cnt_nxt   = cnt + CW'(1);
               end
            end
            CMD_CLEAR: begin
               do_clr  = 1'b1;
               cnt_nxt = '0;
            end
            default: begin
               cnt_nxt = cnt;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         cnt <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_push && int'(cnt) == i)     mem[i] <= push_data;
            if (wr_top  && int'(cnt) == i + 1) mem[i] <= data_in;
            if (do_swap && int'(cnt) == i + 1) mem[i] <= next_val;
            if (do_swap && int'(cnt) == i + 2) mem[i] <= top_val;
         end
         cnt <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
`ifdef OPERAND_STACK_STICKY_ERR_EN
         if (do_clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end else begin
            ovf_q <= ovf_q | ovf_evt;
            unf_q <= unf_q | unf_evt;
         end
`else
         // CLEAR never raises an event, so the pulse form clears naturally.
         ovf_q <= ovf_evt & ~do_clr;
         unf_q <= unf_evt & ~do_clr;
`endif
      end
   end

   assign top   = top_val;
   assign next  = next_val;
   assign count = cnt;
   assign empty = is_empty;
   assign full  = is_full;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule
